// File: rtl/loop_controller_pkg.sv
// ----------------------------------------------------------------------------
// loop_controller_pkg
// Shared constants for the bracket-loop controller: FSM state encodings,
// the bracket opcode byte values and a small opcode decode helper.
// Optional feature macro used by the controller: LOOP_CTRL_STACK_CHECK_EN.
// ----------------------------------------------------------------------------
package loop_controller_pkg;

   // Controller states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EVAL = 2'd1,
      ST_SKIP = 2'd2,
      ST_HALT = 2'd3
   } lc_state_e;

   // Bracket opcode byte values
   localparam logic [7:0] LC_OPEN_OP  = 8'h5B;   // '['
   localparam logic [7:0] LC_CLOSE_OP = 8'h5D;   // ']'

   // Returns 1 when the opcode byte is an opening bracket
   function automatic logic is_open_op(input logic [7:0] opc);
      return (opc == LC_OPEN_OP);
   endfunction

endpackage

// File: rtl/loop_controller_if.sv
// ----------------------------------------------------------------------------
// loop_controller_if
// Bundles the decode-stage bracket handshake and the controller responses.
//   master : decode/pipeline side (drives op_*, cell_*; sees ack/jump/scan/halt)
//   slave  : loop_controller side
// Signals:
//   op_valid, op_open, op_pc  - bracket op presented by decode, held until op_ack
//   cell_valid, cell_zero     - data cell zero flag, valid once pipeline drained
//   op_ack                    - one-cycle op consumed pulse
//   jump, jump_pc, flush      - backward branch request with pipeline flush
//   scan                      - skip mode, core discards non-bracket ops
//   halt                      - sticky stack error halt
// ----------------------------------------------------------------------------
interface loop_controller_if #(
   parameter int IA_WIDTH = 12
);
   logic                op_valid;
   logic                op_open;
   logic [IA_WIDTH-1:0] op_pc;
   logic                cell_valid;
   logic                cell_zero;
   logic                op_ack;
   logic                jump;
   logic [IA_WIDTH-1:0] jump_pc;
   logic                flush;
   logic                scan;
   logic                halt;

   modport master (
      output op_valid, op_open, op_pc, cell_valid, cell_zero,
      input  op_ack, jump, jump_pc, flush, scan, halt
   );

   modport slave (
      input  op_valid, op_open, op_pc, cell_valid, cell_zero,
      output op_ack, jump, jump_pc, flush, scan, halt
   );
endinterface

// File: rtl/loop_controller_stack.sv
// ----------------------------------------------------------------------------
// loop_stack
// LIFO of loop-return addresses for loop_controller.
// Ports:
//   clk, reset      - clock, synchronous active-low reset (pointer only)
//   push, push_data - write push_data; on a full stack the top entry is
//                     overwritten and the pointer holds
//   pop             - drop the top entry; on an empty stack the pointer holds
//   top             - top entry (entry 0 when empty)
//   full, empty     - derived from the SD_LOG2+1 bit pointer
// Contents are not cleared by reset.
// ----------------------------------------------------------------------------
module loop_stack #(
   parameter int IA_WIDTH = 12,
   parameter int SD_LOG2  = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                push,
   input  logic                pop,
   input  logic [IA_WIDTH-1:0] push_data,
   output logic [IA_WIDTH-1:0] top,
   output logic                full,
   output logic                empty
);
   localparam int DEPTH = 1 << SD_LOG2;

   logic [IA_WIDTH-1:0] mem_r [DEPTH];
   logic [SD_LOG2:0]    ptr_r;
   logic [SD_LOG2-1:0]  top_idx_s;
   logic [SD_LOG2-1:0]  wr_idx_s;

   assign full  = ptr_r[SD_LOG2];
   assign empty = (ptr_r == {(SD_LOG2+1){1'b0}});

   // Top-of-stack and write index; a full pointer wraps its low bits to 0,
   // so subtracting one lands on the last entry
   always_comb begin
      top_idx_s = {SD_LOG2{1'b0}};
      wr_idx_s  = ptr_r[SD_LOG2-1:0];
      if (empty) begin
         top_idx_s = {SD_LOG2{1'b0}};
      end else begin
         top_idx_s = ptr_r[SD_LOG2-1:0] - {{(SD_LOG2-1){1'b0}}, 1'b1};
      end
      if (full) begin
         wr_idx_s = top_idx_s;
      end else begin
         wr_idx_s = ptr_r[SD_LOG2-1:0];
      end
   end

   assign top = mem_r[top_idx_s];

   // Stack pointer, saturating at both ends
   always_ff @(posedge clk) begin
      if (!reset) begin
         ptr_r <= {(SD_LOG2+1){1'b0}};
      end else if (push && !full) begin
         ptr_r <= ptr_r + {{SD_LOG2{1'b0}}, 1'b1};
      end else if (pop && !empty) begin
         ptr_r <= ptr_r - {{SD_LOG2{1'b0}}, 1'b1};
      end else begin
         ptr_r <= ptr_r;
      end
   end

   // Entry storage
   always_ff @(posedge clk) begin
      if (push) begin
         mem_r[wr_idx_s] <= push_data;
      end
   end

endmodule

// File: rtl/loop_controller.sv
// ----------------------------------------------------------------------------
// loop_controller
// Resolves '[' / ']' bracket ops for a bracket-language core: pushes loop
// return addresses, issues backward jumps with pipeline flush, and runs a
// nested skip scan when a loop is entered with a zero cell.
// Ports:
//   clk   - clock, all state changes on the rising edge
//   reset - synchronous active-low reset
//   bus   - loop_controller_if.slave (op handshake, cell flag, jump/scan/halt)
// Parameters: IA_WIDTH (instruction address width), SD_LOG2 (log2 stack depth)
// Build option: LOOP_CTRL_STACK_CHECK_EN - when defined, stack overflow and
// underflow acknowledge the op and enter a sticky HALT; otherwise halt is 0,
// overflow overwrites the top entry and underflow uses entry 0.
// ----------------------------------------------------------------------------
module loop_controller
   import loop_controller_pkg::*;
#(
   parameter int IA_WIDTH = 12,
   parameter int SD_LOG2  = 4
) (
   input  logic              clk,
   input  logic              reset,
   loop_controller_if.slave  bus
);
   localparam logic [IA_WIDTH:0]   NEST_ONE = {{IA_WIDTH{1'b0}}, 1'b1};
   localparam logic [IA_WIDTH-1:0] PC_ONE   = {{(IA_WIDTH-1){1'b0}}, 1'b1};

   lc_state_e           state_r, state_s;
   logic                open_r, open_s;
   logic [IA_WIDTH-1:0] pc_r, pc_s;
   logic [IA_WIDTH:0]   nest_r, nest_s;
   logic                op_ack_r, op_ack_s;
   logic                jump_r, jump_s;
   logic [IA_WIDTH-1:0] jump_pc_r, jump_pc_s;
   logic                flush_r;
   logic                scan_r, scan_s;

   logic                push_s, pop_s;
   logic [IA_WIDTH-1:0] stk_top_s;
   logic                stk_full_s, stk_empty_s;
   logic                ovf_s, udf_s;

   loop_stack #(
      .IA_WIDTH (IA_WIDTH),
      .SD_LOG2  (SD_LOG2)
   ) u_stack (
      .clk       (clk),
      .reset     (reset),
      .push      (push_s),
      .pop       (pop_s),
      .push_data (pc_r + PC_ONE),
      .top       (stk_top_s),
      .full      (stk_full_s),
      .empty     (stk_empty_s)
   );

`ifdef LOOP_CTRL_STACK_CHECK_EN
   assign ovf_s = stk_full_s;
   assign udf_s = stk_empty_s;
`else
   logic stack_unused_s;
   assign ovf_s          = 1'b0;
   assign udf_s          = 1'b0;
   assign stack_unused_s = stk_full_s | stk_empty_s;
`endif

   // Next-state, stack control and next output values
   always_comb begin
      state_s   = state_r;
      open_s    = open_r;
      pc_s      = pc_r;
      nest_s    = nest_r;
      op_ack_s  = 1'b0;
      jump_s    = 1'b0;
      jump_pc_s = {IA_WIDTH{1'b0}};
      push_s    = 1'b0;
      pop_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            // An op still presented during its own ack cycle is the old op
            if (bus.op_valid && !op_ack_r) begin
               open_s  = bus.op_open;
               pc_s    = bus.op_pc;
               state_s = ST_EVAL;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_EVAL: begin
            if (bus.cell_valid) begin
               op_ack_s = 1'b1;
               state_s  = ST_IDLE;
               if (open_r) begin
                  if (bus.cell_zero) begin
                     nest_s  = NEST_ONE;
                     state_s = ST_SKIP;
                  end else if (ovf_s) begin
                     state_s = ST_HALT;
                  end else begin
                     push_s = 1'b1;
                  end
               end else begin
                  if (udf_s) begin
                     state_s = ST_HALT;
                  end else if (bus.cell_zero) begin
                     pop_s = 1'b1;
                  end else begin
                     jump_s    = 1'b1;
                     jump_pc_s = stk_top_s;
                  end
               end
            end else begin
               state_s = ST_EVAL;
            end
         end
         ST_SKIP: begin
            if (bus.op_valid && !op_ack_r) begin
               op_ack_s = 1'b1;
               if (bus.op_open) begin
                  nest_s  = nest_r + NEST_ONE;
                  state_s = ST_SKIP;
               end else begin
                  nest_s = nest_r - NEST_ONE;
                  if (nest_r == NEST_ONE) begin
                     state_s = ST_IDLE;
                  end else begin
                     state_s = ST_SKIP;
                  end
               end
            end else begin
               state_s = ST_SKIP;
            end
         end
         ST_HALT: begin
            state_s = ST_HALT;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
      // scan spans the whole SKIP residency plus the closing ack cycle
      scan_s = (state_s == ST_SKIP) || (state_r == ST_SKIP);
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r   <= ST_IDLE;
         open_r    <= 1'b0;
         pc_r      <= {IA_WIDTH{1'b0}};
         nest_r    <= {(IA_WIDTH+1){1'b0}};
         op_ack_r  <= 1'b0;
         jump_r    <= 1'b0;
         jump_pc_r <= {IA_WIDTH{1'b0}};
         flush_r   <= 1'b0;
         scan_r    <= 1'b0;
      end else begin
         state_r   <= state_s;
         open_r    <= open_s;
         pc_r      <= pc_s;
         nest_r    <= nest_s;
         op_ack_r  <= op_ack_s;
         jump_r    <= jump_s;
         jump_pc_r <= jump_pc_s;
         flush_r   <= jump_s;
         scan_r    <= scan_s;
      end
   end

`ifdef LOOP_CTRL_STACK_CHECK_EN
   logic halt_r;

   // Sticky halt flag, cleared only by reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         halt_r <= 1'b0;
      end else begin
         halt_r <= (state_s == ST_HALT);
      end
   end

   assign bus.halt = halt_r;
`else
   assign bus.halt = 1'b0;
`endif

   assign bus.op_ack  = op_ack_r;
   assign bus.jump    = jump_r;
   assign bus.jump_pc = jump_pc_r;
   assign bus.flush   = flush_r;
   assign bus.scan    = scan_r;

endmodule

// File: tb/tb_loop_controller.sv
// ----------------------------------------------------------------------------
// tb_loop_controller
// Directed bench for loop_controller. Each op is presented until acked and
// held through the ack cycle; observed values in the ack cycle are packed as
// {jump, flush, scan, halt, jump_pc[11:0]}, and the cycle after as
// {op_ack, jump, flush, scan}.
// ----------------------------------------------------------------------------
module tb_loop_controller;
   import loop_controller_pkg::*;

   localparam int ACK_BUDGET = 20;
   localparam int NO_ACK     = 99;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   loop_controller_if #(.IA_WIDTH(12)) bus ();

   loop_controller #(
      .IA_WIDTH (12),
      .SD_LOG2  (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] all_outs();
      return {15'd0, bus.op_ack, bus.jump, bus.flush, bus.scan, bus.halt, bus.jump_pc};
   endfunction

   task automatic pulse_reset(input string tag);
      bus.op_valid   = 1'b0;
      bus.cell_valid = 1'b0;
      reset          = 1'b0;
      @(posedge clk); #1;
      check_eq(tag, all_outs(), 32'd0);
      reset = 1'b1;
   endtask

   task automatic run_op(input logic [7:0] opc, input logic [11:0] pc, input logic zero,
                         input logic cv, output int lat, output logic [15:0] obs,
                         output logic [3:0] post);
      logic acked;
      acked          = 1'b0;
      lat            = 0;
      obs            = 16'h0000;
      bus.op_valid   = 1'b1;
      bus.op_open    = is_open_op(opc);
      bus.op_pc      = pc;
      bus.cell_zero  = zero;
      bus.cell_valid = cv;
      while (!acked && lat < ACK_BUDGET) begin
         @(posedge clk); #1;
         lat++;
         if (bus.op_ack) begin
            acked = 1'b1;
            obs   = {bus.jump, bus.flush, bus.scan, bus.halt, bus.jump_pc};
         end
      end
      if (!acked) lat = NO_ACK;
      // op stays presented through the ack cycle, like a real decode stage
      @(posedge clk); #1;
      post           = {bus.op_ack, bus.jump, bus.flush, bus.scan};
      bus.op_valid   = 1'b0;
      bus.cell_valid = 1'b0;
   endtask

   task automatic op_chk(input string tag, input logic [7:0] opc, input logic [11:0] pc,
                         input logic zero, input logic cv, input int exp_lat,
                         input logic [15:0] exp_obs, input logic [3:0] exp_post);
      int          lat;
      logic [15:0] obs;
      logic [3:0]  post;
      run_op(opc, pc, zero, cv, lat, obs, post);
      check_eq({tag, ".lat"},  32'(lat), 32'(exp_lat));
      check_eq({tag, ".obs"},  {16'd0, obs}, {16'd0, exp_obs});
      check_eq({tag, ".post"}, {28'd0, post}, {28'd0, exp_post});
   endtask

   // ']' with non-zero cell on an empty stack
   task automatic underflow_probe(input string tag, input logic [11:0] entry0);
`ifdef LOOP_CTRL_STACK_CHECK_EN
      op_chk(tag, LC_CLOSE_OP, 12'h7F0, 1'b0, 1'b1, 2, 16'h1000, 4'b0000);
      op_chk({tag, ".halted"}, LC_OPEN_OP, 12'h7F1, 1'b0, 1'b1, NO_ACK, 16'h0000, 4'b0000);
      pulse_reset({tag, ".rst"});
`else
      op_chk(tag, LC_CLOSE_OP, 12'h7F0, 1'b0, 1'b1, 2, {4'hC, entry0}, 4'b0000);
`endif
   endtask

   initial begin
      int acks;
      n_checks       = 0;
      n_fail         = 0;
      reset          = 1'b0;
      bus.op_valid   = 1'b0;
      bus.op_open    = 1'b0;
      bus.op_pc      = 12'h000;
      bus.cell_valid = 1'b0;
      bus.cell_zero  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("reset_outs", all_outs(), 32'd0);
      reset = 1'b1;

      // push, jump back, depth unchanged, pop
      op_chk("open_nz",      LC_OPEN_OP,  12'h010, 1'b0, 1'b1, 2, 16'h0000, 4'b0000);
      op_chk("close_jump",   LC_CLOSE_OP, 12'h020, 1'b0, 1'b1, 2, 16'hC011, 4'b0000);
      op_chk("close_jump2",  LC_CLOSE_OP, 12'h020, 1'b0, 1'b1, 2, 16'hC011, 4'b0000);
      op_chk("close_pop",    LC_CLOSE_OP, 12'h020, 1'b1, 1'b1, 2, 16'h0000, 4'b0000);
      // stack now empty: a new push lands in entry 0
      op_chk("refill",       LC_OPEN_OP,  12'h040, 1'b0, 1'b1, 2, 16'h0000, 4'b0000);
      op_chk("refill_pop",   LC_CLOSE_OP, 12'h041, 1'b1, 1'b1, 2, 16'h0000, 4'b0000);
      underflow_probe("underflow", 12'h041);

      // skip over a nested loop body
      op_chk("skip_enter",   LC_OPEN_OP,  12'h100, 1'b1, 1'b1, 2, 16'h2000, 4'b0001);
      op_chk("skip_open",    LC_OPEN_OP,  12'h101, 1'b0, 1'b0, 1, 16'h2000, 4'b0001);
      op_chk("skip_close1",  LC_CLOSE_OP, 12'h102, 1'b0, 1'b0, 1, 16'h2000, 4'b0001);
      op_chk("skip_close0",  LC_CLOSE_OP, 12'h103, 1'b0, 1'b0, 1, 16'h2000, 4'b0000);

      // return address wraps modulo 2^12
      op_chk("wrap_open",    LC_OPEN_OP,  12'hFFF, 1'b0, 1'b1, 2, 16'h0000, 4'b0000);
      op_chk("wrap_jump",    LC_CLOSE_OP, 12'h200, 1'b0, 1'b1, 2, 16'hC000, 4'b0000);
      op_chk("wrap_pop",     LC_CLOSE_OP, 12'h200, 1'b1, 1'b1, 2, 16'h0000, 4'b0000);

      // cell_valid late by 5 cycles
      bus.op_valid   = 1'b1;
      bus.op_open    = is_open_op(LC_OPEN_OP);
      bus.op_pc      = 12'h300;
      bus.cell_zero  = 1'b0;
      bus.cell_valid = 1'b0;
      acks = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (bus.op_ack) acks++;
      end
      check_eq("late_cv.noack", 32'(acks), 32'd0);
      bus.cell_valid = 1'b1;
      @(posedge clk); #1;
      check_eq("late_cv.ack", {31'd0, bus.op_ack}, 32'd1);
      @(posedge clk); #1;
      check_eq("late_cv.single", {31'd0, bus.op_ack}, 32'd0);
      bus.op_valid   = 1'b0;
      bus.cell_valid = 1'b0;

      // reset while stalled in EVAL, pointer returns to 0
      bus.op_valid   = 1'b1;
      bus.op_open    = is_open_op(LC_OPEN_OP);
      bus.op_pc      = 12'h350;
      bus.cell_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      pulse_reset("rst_eval");
      op_chk("post_rst_open", LC_OPEN_OP,  12'h400, 1'b0, 1'b1, 2, 16'h0000, 4'b0000);
      op_chk("post_rst_pop",  LC_CLOSE_OP, 12'h410, 1'b1, 1'b1, 2, 16'h0000, 4'b0000);
      underflow_probe("post_rst_udf", 12'h401);

      // reset while in SKIP drops scan and the nest count
      op_chk("skip2_enter",  LC_OPEN_OP,  12'h500, 1'b1, 1'b1, 2, 16'h2000, 4'b0001);
      pulse_reset("rst_skip");
      op_chk("skip2_after",  LC_OPEN_OP,  12'h510, 1'b0, 1'b1, 2, 16'h0000, 4'b0000);
      op_chk("skip2_pop",    LC_CLOSE_OP, 12'h520, 1'b1, 1'b1, 2, 16'h0000, 4'b0000);

      // 17 nested pushes into a 16-entry stack
      pulse_reset("rst_fill");
      for (int i = 0; i < 16; i++) begin
         op_chk($sformatf("fill%0d", i), LC_OPEN_OP, 12'h600 + 12'(i), 1'b0, 1'b1,
                2, 16'h0000, 4'b0000);
      end
`ifdef LOOP_CTRL_STACK_CHECK_EN
      op_chk("fill16_ovf",   LC_OPEN_OP,  12'h610, 1'b0, 1'b1, 2, 16'h1000, 4'b0000);
      op_chk("halt_ignore",  LC_CLOSE_OP, 12'h620, 1'b0, 1'b1, NO_ACK, 16'h0000, 4'b0000);
`else
      op_chk("fill16_ovw",   LC_OPEN_OP,  12'h610, 1'b0, 1'b1, 2, 16'h0000, 4'b0000);
      op_chk("full_jump",    LC_CLOSE_OP, 12'h620, 1'b0, 1'b1, 2, 16'hC611, 4'b0000);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/loop_controller.md
LOOP_CONTROLLER -- requirements
Module: loop_controller

Interface
REQ-001 Parameters SHALL be: IA_WIDTH, 12, instruction address width; SD_LOG2, 4, log2 of loop stack depth (16 entries).
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 op_valid  in  1  decode stage presents a bracket op; held until op_ack.
REQ-005 op_open  in  1  1 = '[', 0 = ']'; stable while op_valid.
REQ-006 op_pc  in  IA_WIDTH  address of the bracket instruction.
REQ-007 cell_valid  in  1  pipeline drained; cell_zero is current for DP.
REQ-008 cell_zero  in  1  current data cell equals 0.
REQ-009 op_ack  out  1  one-cycle pulse; op consumed.
REQ-010 jump  out  1  one-cycle pulse; PC loads jump_pc.
REQ-011 jump_pc  out  IA_WIDTH  jump target; valid only with jump.
REQ-012 flush  out  1  one-cycle pulse with jump; squashes IF/ID/DF/M contents.
REQ-013 scan  out  1  skip mode; core discards all non-bracket ops.
REQ-014 halt  out  1  sticky error halt (see Configuration).

Function
REQ-015 States SHALL be IDLE, EVAL, SKIP, HALT; outputs registered.
REQ-016 IDLE: op_valid=1 -> capture op_open/op_pc, go EVAL; no ack this cycle.
REQ-017 EVAL: wait while cell_valid=0; decide in the first cycle cell_valid=1; op_ack pulses the next cycle, state returns IDLE unless stated.
REQ-018 '[' with cell_zero=0: push op_pc+1 (mod 2^IA_WIDTH), no jump.
REQ-019 '[' with cell_zero=1: no push; nest counter := 1; go SKIP.
REQ-020 ']' with cell_zero=1: pop; no jump.
REQ-021 ']' with cell_zero=0: no pop; jump=flush=1, jump_pc=top of stack, same cycle as op_ack.
REQ-022 SKIP: scan=1; each op_valid acked next cycle without cell_valid; '[' nest+1, ']' nest-1; nest reaching 0 -> IDLE, scan=0 the cycle after that ack.
REQ-023 Nest counter SHALL be IA_WIDTH+1 bits; cannot overflow in a valid program.
REQ-024 op_valid in the op_ack cycle SHALL be ignored (no double accept).
REQ-025 Stack SHALL hold 2^SD_LOG2 entries; full and empty derived from an SD_LOG2+1-bit pointer.
REQ-026 Push to full stack = overflow; pop or ']' decision on empty stack = underflow.

Reset
REQ-027 reset=0 at a clock edge SHALL force IDLE, pointer 0, nest 0, and op_ack, jump, flush, scan, halt, jump_pc all 0, including mid-EVAL or mid-SKIP.
REQ-028 Stack contents need not be cleared.

Configuration
REQ-029 Macro LOOP_CTRL_STACK_CHECK_EN defined: overflow/underflow -> op_ack pulses, no stack change, no jump, go HALT; halt=1 until reset; ops ignored.
REQ-030 LOOP_CTRL_STACK_CHECK_EN undefined: halt tied 0, HALT unreachable; overflow overwrites the top entry; underflow leaves the pointer at 0, and ']' non-zero jumps to entry 0.

Structure
REQ-031 State encodings, bracket opcode values ('[' = 8'h5B, ']' = 8'h5D) SHALL live in the shared constants file.
REQ-032 LIFO SHALL be sub-module loop_stack (push, pop, top, full, empty).

Verification
REQ-033 op '[' pc=0x010, cell_zero=0 -> op_ack, no jump, top=0x011; then ']' pc=0x020, cell_zero=0 -> jump=flush=1, jump_pc=0x011, depth stays 1.
REQ-034 Same ']' with cell_zero=1 -> op_ack, no jump, stack empty.
REQ-035 '[' cell_zero=1, then ops '[',']',']' -> scan=1 throughout, each acked, scan=0 after the final ']'.
REQ-036 17 consecutive '[' cell_zero=0 with STACK_CHECK_EN -> 17th acked, halt=1, later ops never acked; without macro -> no halt, top=last pc+1.
REQ-037 reset=0 during EVAL with cell_valid held 0 -> next cycle all outputs 0, IDLE; fresh '[' behaves per REQ-018.
REQ-038 cell_valid held 0 for 5 cycles in EVAL -> no op_ack until 1 cycle after cell_valid rises.
